// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave block.
package spi_slave_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int              BYTE_W     = 8;
  localparam logic [BYTE_W-1:0] FILL     = 8'hFF;
  localparam int              SYNC_DEPTH = 2;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus host-side byte interface of the SPI slave.
interface spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int CW = 4
) ();
  logic              ss;
  logic              ck;
  logic              mosi;
  logic              miso;
  logic [BYTE_W-1:0] d;
  logic              ld;
  logic              txe;
  logic [BYTE_W-1:0] q;
  logic              rxr;
  logic [CW-1:0]     count;
  logic              active;

  modport slave  (input  ss, ck, mosi, d, ld,
                  output miso, txe, q, rxr, count, active);
  modport master (output ss, ck, mosi, d, ld,
                  input  miso, txe, q, rxr, count, active);
endinterface

// File: rtl/spi_slave_sync.sv
// One-bit multi-flop synchroniser with configurable reset level.
module spi_sync
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [SYNC_DEPTH-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) chain <= {SYNC_DEPTH{RST_VAL}};
    else        chain <= {chain[SYNC_DEPTH-2:0], din};
  end

  assign dout = chain[SYNC_DEPTH-1];
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by the system clock.
// Optional transmit holding register enabled by defining SPI_SLAVE_TXBUF_EN;
// without it d is sampled directly at every transmit load and txe is tied 1.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic         clock,
  input  logic         reset,
  spi_slave_if.slave   bus
);
  logic              ss_s, ck_s, mosi_s;
  logic              ss_d, ck_d;
  logic              ss_fall, ss_rise, ck_rise, ck_fall;
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] rx_sr, tx_sr, q_r, load_val;
  logic              rxr_r, active_r;
  logic              skip_sh;
  logic [CW-1:0]     cnt;

  spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.clock(clock), .reset(reset), .din(bus.ss),   .dout(ss_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_ck   (.clock(clock), .reset(reset), .din(bus.ck),   .dout(ck_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_mosi (.clock(clock), .reset(reset), .din(bus.mosi), .dout(mosi_s));

  assign ss_fall = ss_d & ~ss_s;
  assign ss_rise = ~ss_d & ss_s;
  assign ck_rise = ck_s & ~ck_d;
  assign ck_fall = ~ck_s & ck_d;

`ifdef SPI_SLAVE_TXBUF_EN
  logic              txe_r;
  logic [BYTE_W-1:0] hold;
  logic              load_evt;

  // A load happens on frame entry and on every completed byte.
  assign load_evt = ((state == IDLE) && ss_fall) ||
                    ((state == SHIFT) && !ss_rise && ck_rise && (bit_cnt == 3'd7));
  // ld coincident with a load bypasses the holding register.
  assign load_val = bus.ld ? bus.d : (txe_r ? FILL : hold);

  // Holding register: filled by ld, drained by each load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txe_r <= 1'b1;
      hold  <= FILL;
    end else if (load_evt) begin
      txe_r <= 1'b1;
    end else if (bus.ld) begin
      hold  <= bus.d;
      txe_r <= 1'b0;
    end
  end

  assign bus.txe = txe_r;
`else
  logic unused_ld;
  assign unused_ld = bus.ld;
  assign load_val  = bus.d;
  assign bus.txe   = 1'b1;
`endif

  // Frame FSM with receive/transmit shifting. A load at the 8th rising
  // edge arms skip_sh so the falling edge that follows does not shift
  // the fresh MSB away before the master samples it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ss_d     <= 1'b1;
      ck_d     <= 1'b0;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= FILL;
      q_r      <= '0;
      rxr_r    <= 1'b0;
      active_r <= 1'b0;
      skip_sh  <= 1'b0;
      cnt      <= '0;
    end else begin
      ss_d  <= ss_s;
      ck_d  <= ck_s;
      rxr_r <= 1'b0;
      case (state)
        IDLE: begin
          // ck edges in the start cycle are deliberately ignored
          if (ss_fall) begin
            state    <= SHIFT;
            active_r <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sr    <= load_val;
            skip_sh  <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            // partial byte is dropped: no rxr, q untouched
            state    <= IDLE;
            active_r <= 1'b0;
            bit_cnt  <= '0;
            tx_sr    <= FILL;
            skip_sh  <= 1'b0;
          end else if (ck_rise) begin
            rx_sr   <= {rx_sr[BYTE_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              q_r     <= {rx_sr[BYTE_W-2:0], mosi_s};
              rxr_r   <= 1'b1;
              tx_sr   <= load_val;
              skip_sh <= 1'b1;
              if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
            end
          end else if (ck_fall) begin
            if (skip_sh) skip_sh <= 1'b0;
            else         tx_sr   <= {tx_sr[BYTE_W-2:0], 1'b1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.miso   = tx_sr[BYTE_W-1];
  assign bus.q      = q_r;
  assign bus.rxr    = rxr_r;
  assign bus.count  = cnt;
  assign bus.active = active_r;
endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus pushes expected received bytes,
// a monitor pops them on every rxr pulse.
module tb_spi_slave;
  localparam int HALF = 5;   // SCK half period in system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ss = 1'b1, ck = 1'b0, mosi = 1'b1, ld = 1'b0;
  logic [7:0] d = 8'h3C;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  spi_slave_if #(.CW(4)) sif ();
  spi_slave_if #(.CW(2)) sif2 ();

  assign sif.ss = ss;   assign sif.ck = ck;   assign sif.mosi = mosi;
  assign sif.d  = d;    assign sif.ld = ld;
  assign sif2.ss = ss;  assign sif2.ck = ck;  assign sif2.mosi = mosi;
  assign sif2.d  = d;   assign sif2.ld = ld;

  spi_slave #(.CW(4)) dut  (.clock(clock), .reset(reset), .bus(sif));
  spi_slave #(.CW(2)) dut2 (.clock(clock), .reset(reset), .bus(sif2));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Master shifts nbits of tx MSB first and samples miso before each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      clks(HALF);
      rx[i] = sif.miso;
      ck = 1'b1;
      clks(HALF);
      ck = 1'b0;
    end
  endtask

  task automatic frame_start;
    ss = 1'b0;
    clks(HALF);
  endtask

  task automatic frame_end;
    clks(HALF);
    ss = 1'b1;
    clks(HALF);
  endtask

  // Monitor: every rxr pulse must match the oldest expected byte and last one cycle.
  initial begin
    logic prev_rxr;
    logic [7:0] e;
    prev_rxr = 1'b0;
    forever begin
      @(negedge clock);
      if (sif.rxr) begin
        chk("rxr_single_cycle", {31'b0, prev_rxr}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rxr: q=%0h with nothing expected", sif.q);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", {24'b0, sif.q}, {24'b0, e});
        end
      end
      prev_rxr = sif.rxr;
    end
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] fill_or_d;
`ifdef SPI_SLAVE_TXBUF_EN
    fill_or_d = 8'hFF;
`else
    fill_or_d = 8'h3C;
`endif

    // reset state
    clks(3);
    chk("rst_miso",   {31'b0, sif.miso},   32'd1);
    chk("rst_txe",    {31'b0, sif.txe},    32'd1);
    chk("rst_q",      {24'b0, sif.q},      32'h00);
    chk("rst_rxr",    {31'b0, sif.rxr},    32'd0);
    chk("rst_count",  {28'b0, sif.count},  32'd0);
    chk("rst_active", {31'b0, sif.active}, 32'd0);
    reset = 1'b1;
    clks(3);

    // single byte A5 in, 3C out
    d = 8'h3C; ld = 1'b1; clks(1); ld = 1'b0;
`ifdef SPI_SLAVE_TXBUF_EN
    chk("txe_after_ld", {31'b0, sif.txe}, 32'd0);
`else
    chk("txe_tied", {31'b0, sif.txe}, 32'd1);
`endif
    frame_start();
    chk("active_start", {31'b0, sif.active}, 32'd1);
    chk("count_start",  {28'b0, sif.count},  32'd0);
    exp_q.push_back(8'hA5);
    spi_bits(8'hA5, 8, rx);
    chk("miso_a5", {24'b0, rx}, 32'h3C);
    chk("count_a5", {28'b0, sif.count}, 32'd1);
    frame_end();
    chk("active_end", {31'b0, sif.active}, 32'd0);
    chk("miso_idle", {31'b0, sif.miso}, 32'd1);

    // three-byte frame
    frame_start();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      spi_bits(8'(i), 8, rx);
      chk("miso_3byte", {24'b0, rx}, {24'b0, fill_or_d});
      chk("count_3byte", {28'b0, sif.count}, 32'(i));
    end
    frame_end();
    chk("active_3end", {31'b0, sif.active}, 32'd0);
    chk("miso_3idle", {31'b0, sif.miso}, 32'd1);
    chk("q_hold", {24'b0, sif.q}, 32'h03);

    // partial byte then a fresh frame
    frame_start();
    spi_bits(8'hFF, 5, rx);
    ss = 1'b1;
    clks(2 * HALF);
    chk("q_after_partial", {24'b0, sif.q}, 32'h03);
    frame_start();
    exp_q.push_back(8'h81);
    spi_bits(8'h81, 8, rx);
    frame_end();

`ifdef SPI_SLAVE_TXBUF_EN
    // buffered byte then underrun fill
    d = 8'h55; ld = 1'b1; clks(1); ld = 1'b0; d = 8'h00;
    chk("txe_loaded", {31'b0, sif.txe}, 32'd0);
    frame_start();
    chk("txe_after_entry", {31'b0, sif.txe}, 32'd1);
    exp_q.push_back(8'h11);
    spi_bits(8'h11, 8, rx);
    chk("txbuf_byte0", {24'b0, rx}, 32'h55);
    exp_q.push_back(8'h22);
    spi_bits(8'h22, 8, rx);
    chk("txbuf_byte1", {24'b0, rx}, 32'hFF);
    frame_end();
    d = 8'h3C;
`endif

    // reset mid-byte
    frame_start();
    spi_bits(8'hC3, 4, rx);
    reset = 1'b0;
    #1;
    chk("mid_rst_miso",   {31'b0, sif.miso},   32'd1);
    chk("mid_rst_txe",    {31'b0, sif.txe},    32'd1);
    chk("mid_rst_q",      {24'b0, sif.q},      32'h00);
    chk("mid_rst_rxr",    {31'b0, sif.rxr},    32'd0);
    chk("mid_rst_count",  {28'b0, sif.count},  32'd0);
    chk("mid_rst_active", {31'b0, sif.active}, 32'd0);
    ss = 1'b1; mosi = 1'b1;
    clks(3);
    reset = 1'b1;
    clks(3);
    frame_start();
    exp_q.push_back(8'h7E);
    spi_bits(8'h7E, 8, rx);
    frame_end();
    chk("q_7e", {24'b0, sif.q}, 32'h7E);

    // count saturation with CW=2 alongside CW=4
    frame_start();
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      spi_bits(8'(8'h10 + i), 8, rx);
      chk("count_cw4", {28'b0, sif.count}, 32'(i));
      chk("count_cw2_sat", {30'b0, sif2.count}, (i > 3) ? 32'd3 : 32'(i));
    end
    frame_end();

    clks(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
